// File: rtl/butterfly_unit_pkg.sv
// Shared constants for the FFT datapath: default word format and pipeline depth.
package butterfly_unit_pkg;

    localparam int N_DEFAULT = 16;
    localparam int Q_DEFAULT = 8;
    localparam int LATENCY   = 3;

endpackage

// File: rtl/butterfly_unit_cmul_core.sv
// Registered complex multiplier: S1 captures operands, S2 holds the four real
// sign-magnitude products of b and w alongside the delayed a operand.
module cmul_core
    import butterfly_unit_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int Q = Q_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    input  logic [N-1:0] a_re,
    input  logic [N-1:0] a_im,
    input  logic [N-1:0] b_re,
    input  logic [N-1:0] b_im,
    input  logic [N-1:0] w_re,
    input  logic [N-1:0] w_im,
    output logic         out_valid,
    output logic [N-1:0] a_re_d,
    output logic [N-1:0] a_im_d,
    output logic [N-1:0] p_rr,
    output logic [N-1:0] p_ii,
    output logic [N-1:0] p_ri,
    output logic [N-1:0] p_ir
);

    logic         v1;
    logic [N-1:0] a1_re, a1_im, b1_re, b1_im, w1_re, w1_im;

    // Truncates toward zero; the most-negative input keeps magnitude 2^(N-1).
    function automatic logic [N-1:0] prod(input logic [N-1:0] s, input logic [N-1:0] t);
        logic [N-1:0]   ms;
        logic [N-1:0]   mt;
        logic [2*N-1:0] full;
        logic [N-1:0]   trunc;
        // NOTE: function locals are combinational temporaries, so blocking '=' is correct here.
        ms    = s[N-1] ? -s : s;
        mt    = t[N-1] ? -t : t;
        full  = {{N{1'b0}}, ms} * {{N{1'b0}}, mt};
        trunc = N'(full >> Q);
        return (s[N-1] ^ t[N-1]) ? -trunc : trunc;
    endfunction

    // NOTE: data registers are cleared on reset as well as valids, so outputs read zero while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            a1_re     <= '0;
            a1_im     <= '0;
            b1_re     <= '0;
            b1_im     <= '0;
            w1_re     <= '0;
            w1_im     <= '0;
            out_valid <= 1'b0;
            a_re_d    <= '0;
            a_im_d    <= '0;
            p_rr      <= '0;
            p_ii      <= '0;
            p_ri      <= '0;
            p_ir      <= '0;
        end else if (en) begin
            v1        <= in_valid;
            a1_re     <= a_re;
            a1_im     <= a_im;
            b1_re     <= b_re;
            b1_im     <= b_im;
            w1_re     <= w_re;
            w1_im     <= w_im;
            out_valid <= v1;
            a_re_d    <= a1_re;
            a_im_d    <= a1_im;
            p_rr      <= prod(b1_re, w1_re);
            p_ii      <= prod(b1_im, w1_im);
            p_ri      <= prod(b1_re, w1_im);
            p_ir      <= prod(b1_im, w1_re);
        end
    end

endmodule

// File: rtl/butterfly_unit.sv
// Radix-2 DIT butterfly: x = a + b*w, y = a - b*w, optional divide-by-two,
// three-stage pipeline with a single stall enable driven by out_ready.
module butterfly_unit
    import butterfly_unit_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int Q     = Q_DEFAULT,
    parameter int SCALE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a_re,
    input  logic [N-1:0] a_im,
    input  logic [N-1:0] b_re,
    input  logic [N-1:0] b_im,
    input  logic [N-1:0] w_re,
    input  logic [N-1:0] w_im,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] x_re,
    output logic [N-1:0] x_im,
    output logic [N-1:0] y_re,
    output logic [N-1:0] y_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_ovf
);

    logic                en;
    logic                v2;
    logic [N-1:0]        a_re_d, a_im_d, p_rr, p_ii, p_ri, p_ir;
    logic signed [N:0]   bw_re, bw_im;
    logic signed [N+1:0] xf_re, xf_im, yf_re, yf_im;
    logic signed [N+1:0] xs_re, xs_im, ys_re, ys_im;

    // Whole pipeline advances together; bubbles are kept, never squeezed out.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    cmul_core #(.N(N), .Q(Q)) u_cmul (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .out_valid (v2),
        .a_re_d    (a_re_d),
        .a_im_d    (a_im_d),
        .p_rr      (p_rr),
        .p_ii      (p_ii),
        .p_ri      (p_ri),
        .p_ir      (p_ir)
    );

    function automatic logic signed [N+1:0] scale_fn(input logic signed [N+1:0] v);
        return (SCALE != 0) ? (v >>> 1) : v;
    endfunction

    // In range iff the value equals the sign extension of its low N bits.
    function automatic logic fits(input logic [N+1:0] v);
        return v == {{2{v[N-1]}}, v[N-1:0]};
    endfunction

    assign bw_re = {p_rr[N-1], p_rr} - {p_ii[N-1], p_ii};
    assign bw_im = {p_ri[N-1], p_ri} + {p_ir[N-1], p_ir};
    assign xf_re = {{2{a_re_d[N-1]}}, a_re_d} + {bw_re[N], bw_re};
    assign xf_im = {{2{a_im_d[N-1]}}, a_im_d} + {bw_im[N], bw_im};
    assign yf_re = {{2{a_re_d[N-1]}}, a_re_d} - {bw_re[N], bw_re};
    assign yf_im = {{2{a_im_d[N-1]}}, a_im_d} - {bw_im[N], bw_im};
    assign xs_re = scale_fn(xf_re);
    assign xs_im = scale_fn(xf_im);
    assign ys_re = scale_fn(yf_re);
    assign ys_im = scale_fn(yf_im);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
            x_re      <= '0;
            x_im      <= '0;
            y_re      <= '0;
            y_im      <= '0;
        end else if (en) begin
            out_valid <= v2;
            x_re      <= xs_re[N-1:0];
            x_im      <= xs_im[N-1:0];
            y_re      <= ys_re[N-1:0];
            y_im      <= ys_im[N-1:0];
            out_ovf   <= !(fits(xs_re) && fits(xs_im) && fits(ys_re) && fits(ys_im));
        end
    end

endmodule

// File: doc/butterfly_unit.md
BUTTERFLY_UNIT -- requirements
Module: butterfly_unit

Interface
REQ-001 SHALL have parameter N, default 16, giving the word width of every real or imaginary component (two's complement).
REQ-002 SHALL have parameter Q, default 8, giving the number of fractional bits (Q(N-Q).Q fixed point).
REQ-003 SHALL have parameter SCALE, default 1; when 1, both outputs are divided by 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports a_re and a_im, input, N bits each: butterfly top operand.
REQ-007 SHALL have ports b_re and b_im, input, N bits each: butterfly bottom operand.
REQ-008 SHALL have ports w_re and w_im, input, N bits each: twiddle factor.
REQ-009 SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-011 SHALL have ports x_re and x_im, output, N bits each: x = a + b*w (scaled per SCALE).
REQ-012 SHALL have ports y_re and y_im, output, N bits each: y = a - b*w (scaled per SCALE).
REQ-013 SHALL have port out_valid, input... no: out_valid, output, 1 bit: x and y are valid.
REQ-014 SHALL have port out_ready, input, 1 bit: the downstream stage consumes x and y.
REQ-015 SHALL have port out_ovf, output, 1 bit: at least one of the four output components wrapped.

Function
REQ-016 SHALL transfer an input when in_valid and in_ready are both high, and transfer an output when out_valid and out_ready are both high.
REQ-017 SHALL be a 3-stage pipeline: S1 registers a, b and w; S2 registers the four real products and delayed a; S3 registers x, y and out_ovf.
REQ-018 SHALL give a latency of exactly 3 clk edges from input transfer to out_valid with no stall.
REQ-019 SHALL use a single advance enable en = !out_valid | out_ready, applied to all stages; in_ready = en (combinational).
REQ-020 SHALL leave every stage register, including valid bits, unchanged while en = 0; bubbles are not collapsed.
REQ-021 SHALL hold x, y, out_ovf and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL compute each real product p = s*t as sign-magnitude: |s|*|t| formed at 2N bits, bits [N-1+Q:Q] taken, and the result negated iff exactly one sign is negative (truncation toward zero).
REQ-023 SHALL compute bw_re = p(b_re,w_re) - p(b_im,w_im) and bw_im = p(b_re,w_im) + p(b_im,w_re), each at N+1 bits.
REQ-024 SHALL form x and y at N+2 bits; when SCALE = 1, each SHALL be arithmetically shifted right by 1 (floor); the low N bits are then output.
REQ-025 SHALL set out_ovf when any post-scale x or y value falls outside the signed N-bit range; the wrapped low N bits are still output.
REQ-026 SHALL treat the most-negative input value (0x8000) as magnitude 0x8000 without saturation.

Reset
REQ-027 SHALL, on rst high, immediately clear all valid bits and the data registers, so out_valid = 0, out_ovf = 0, and x/y = 0.
REQ-028 SHALL discard in-flight operands when rst asserts mid-operation; the first output after reset comes from a new transfer at least 3 cycles after release.
REQ-029 SHALL hold in_ready = 1 during and after reset, because out_valid = 0.

Structure
REQ-030 SHALL place N/Q defaults and the stage-count constant LATENCY = 3 in the shared FFT package.
REQ-031 SHALL implement the four REQ-022 products in one sub-module, cmul_core, a registered complex multiplier covering S1 and S2 with an enable input.

Verification
REQ-032 SHALL check, with SCALE=0: a=(0x0100,0), b=(0x0100,0), w=(0x0100,0) -> after 3 cycles x=(0x0200,0), y=(0,0), out_ovf=0.
REQ-033 SHALL check, with SCALE=0: a=(0,0), b=(0x0100,0), w=(0,0xFF00) -> x=(0,0xFF00), y=(0,0x0100).
REQ-034 SHALL check truncation: b=(0xFFFF,0), w=(0x0080,0), a=0 -> x=y=(0,0) (product -0.5 LSB truncates to 0).
REQ-035 SHALL check, with SCALE=0: a=(0x7F00,0), b=(0x0200,0), w=(0x0100,0) -> x_re=0x8100 with out_ovf=1; with SCALE=1 -> x_re=0x4080 with out_ovf=0.
REQ-036 SHALL check stall: stream 5 back-to-back inputs while out_ready is held low for 4 cycles -> in_ready=0 while out_valid=1, no loss or duplication, outputs in order.
REQ-037 SHALL check reset mid-stream: assert rst with 2 items in flight -> out_valid=0 immediately and no stale output after release.
